// File: rtl/id_ex_pipeline.sv
// ID/EX pipeline register with load-use stall detection, flush handling and a saturating bubble counter.
// Optional writeback-to-EX bypass is compiled in with the macro ID_EX_WB_BYPASS_EN.
module id_ex_pipeline #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [15:0]       bubble_cnt
);

  localparam int CTRL_MEM_READ = 1;
  localparam int CTRL_REG_DST  = 5;

  logic              bubble_s;
  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;
  logic [4:0]        dest_s;

  // Load-use hazard: EX holds a load whose target is read by the instruction in ID.
  assign stall = ex_valid & ex_ctrl[CTRL_MEM_READ] & (ex_rt != 5'd0) & id_valid &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));

  assign bubble_s = flush | stall;

`ifdef ID_EX_WB_BYPASS_EN
  // Operand selection: a same-cycle writeback overrides the stale bank read.
  always_comb begin
    rs_data_s = id_rs_data;
    rt_data_s = id_rt_data;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs)) begin
      rs_data_s = wb_data;
    end else begin
      rs_data_s = id_rs_data;
    end
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == id_rt)) begin
      rt_data_s = wb_data;
    end else begin
      rt_data_s = id_rt_data;
    end
  end
`else
  logic unused_wb_s;

  assign unused_wb_s = ^{wb_we, wb_rd, wb_data};

  // Operand selection: bank reads pass through unchanged.
  always_comb begin
    rs_data_s = id_rs_data;
    rt_data_s = id_rt_data;
  end
`endif

  // Destination register selection from reg_dst.
  always_comb begin
    dest_s = id_rt;
    if (id_ctrl[CTRL_REG_DST]) begin
      dest_s = id_rd;
    end else begin
      dest_s = id_rt;
    end
  end

  // EX bundle register: reset, then bubble (flush or stall), then normal load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_rs_data <= {DATA_W{1'b0}};
      ex_rt_data <= {DATA_W{1'b0}};
      ex_imm     <= {DATA_W{1'b0}};
      ex_rs      <= 5'd0;
      ex_rt      <= 5'd0;
      ex_dest    <= 5'd0;
      ex_ctrl    <= {CTRL_W{1'b0}};
    end else if (bubble_s) begin
      ex_valid   <= 1'b0;
      ex_rs_data <= {DATA_W{1'b0}};
      ex_rt_data <= {DATA_W{1'b0}};
      ex_imm     <= {DATA_W{1'b0}};
      ex_rs      <= 5'd0;
      ex_rt      <= 5'd0;
      ex_dest    <= 5'd0;
      ex_ctrl    <= {CTRL_W{1'b0}};
    end else begin
      ex_valid   <= id_valid;
      ex_rs_data <= rs_data_s;
      ex_rt_data <= rt_data_s;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_dest    <= dest_s;
      ex_ctrl    <= id_ctrl;
    end
  end

  // Saturating count of inserted bubbles; idle loads are not bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= 16'd0;
    end else if (bubble_s && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end

endmodule

// File: doc/id_ex_pipeline.md
ID_EX_PIPELINE -- requirements
Module: id_ex_pipeline

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath word width.
REQ-002 SHALL have parameter CTRL_W, default 12, control bundle width.
REQ-003 SHALL have port clk, input, 1: one clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port id_valid, input, 1: ID stage holds a real instruction.
REQ-006 SHALL have ports id_rs_data / id_rt_data, input, DATA_W: register bank read outputs (port 1 / port 2).
REQ-007 SHALL have port id_imm, input, DATA_W: sign-extended immediate.
REQ-008 SHALL have ports id_rs / id_rt / id_rd, input, 5 each: source and destination register indices.
REQ-009 SHALL have port id_ctrl, input, CTRL_W, with these bits: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] alu_src, [5] reg_dst, [9:6] alu_op, [10] branch, [11] jump.
REQ-010 SHALL have port flush, input, 1: kill the instruction entering EX (taken branch or jump).
REQ-011 SHALL have ports wb_we (input, 1), wb_rd (input, 5) and wb_data (input, DATA_W): writeback port, the same values driven to the register bank.
REQ-012 SHALL have port stall, output, 1: load-use hazard; IF and IF/ID hold while it is high.
REQ-013 SHALL have outputs ex_valid (1), ex_rs_data / ex_rt_data / ex_imm (DATA_W), ex_rs / ex_rt / ex_dest (5), ex_ctrl (CTRL_W): registered EX-stage bundle.
REQ-014 SHALL have output bubble_cnt, output, 16: count of inserted bubbles.

Function
REQ-015 stall SHALL be combinational: stall = ex_valid & ex_ctrl[1] & (ex_rt != 0) & id_valid & (ex_rt == id_rs | ex_rt == id_rt).
REQ-016 Per-edge priority SHALL be: rst, then flush, then stall, then normal load.
REQ-017 On normal load, every ex_* output SHALL take the corresponding id_* value one cycle later, ex_valid = id_valid.
REQ-018 ex_dest SHALL be id_rd when id_ctrl[5] = 1, else id_rt, captured at the load edge.
REQ-019 On flush or stall the edge SHALL load a bubble: ex_valid = 0, ex_ctrl = 0, data and index fields = 0.
REQ-020 flush and stall asserted together SHALL produce exactly one bubble; flush wins and the stall condition is re-evaluated on the next cycle.
REQ-021 A stall SHALL last exactly one cycle for a single load-use pair, because the bubble clears ex_ctrl[1].
REQ-022 A stall SHALL NOT be raised when ex_rt = 0; register 0 never creates a hazard.
REQ-023 bubble_cnt SHALL increment by 1 on every edge that loads a bubble because of flush or stall, saturate at 16'hFFFF, and never wrap.
REQ-024 While id_valid = 0 with no flush or stall, a normal load SHALL occur with ex_valid = 0 and SHALL NOT count as a bubble.

Reset
REQ-025 While rst = 1, all outputs SHALL read 0 immediately, without waiting for a clock edge: ex_valid, ex_ctrl, every data field, every index, and bubble_cnt.
REQ-026 rst asserted mid-stall SHALL clear the pipeline; stall deasserts as a consequence of ex_valid = 0.
REQ-027 The first rising edge after rst falls SHALL perform a normal load.

Configuration
REQ-028 Macro ID_EX_WB_BYPASS_EN SHALL control the writeback bypass.
REQ-029 With ID_EX_WB_BYPASS_EN defined, when wb_we = 1, wb_rd != 0 and wb_rd == id_rs, the loaded ex_rs_data SHALL be wb_data; the same rule applies independently to id_rt and ex_rt_data.
REQ-030 Without ID_EX_WB_BYPASS_EN, ex_rs_data and ex_rt_data SHALL always take id_rs_data and id_rt_data unchanged.

Verification
REQ-031 Reset, then id_valid = 1, id_rs_data = 32'h4, id_ctrl[5] = 1, id_rd = 9 -> next edge ex_rs_data = 4 and ex_dest = 9.
REQ-032 EX holds lw with ex_rt = 8; ID holds add with id_rs = 8 -> stall = 1 for one cycle, bubble loaded, add enters EX on the following edge, bubble_cnt = 1.
REQ-033 Same as REQ-032 but ex_rt = 0 -> stall = 0 and no bubble.
REQ-034 flush = 1 with stall = 1 -> one bubble, bubble_cnt increments by 1, not 2.
REQ-035 Bypass compiled in: wb_we = 1, wb_rd = 5, wb_data = 32'hDEAD, id_rs = 5, id_rs_data = 32'h4 -> ex_rs_data = 32'hDEAD; compiled out -> 32'h4.
REQ-036 Force bubble_cnt to 16'hFFFE and apply 3 flush cycles -> bubble_cnt = 16'hFFFF; then raise rst between edges -> all outputs 0 immediately.
